// File: rtl/pong_ball_controller_if.sv
// rtl/pong_ball_controller_if.sv - frame/control inputs and ball/overlay outputs of the pong ball controller
interface pong_ball_controller_if;
    logic        FRAME_TICK;
    logic [7:0]  PADDLE_POSITION;
    logic        SERVE;
    logic [10:0] BALL_X;
    logic [10:0] BALL_Y;
    logic        BALL_VISIBLE;
    logic [7:0]  SCORE;
    logic [1:0]  MISSES;
    logic [2:0]  GAME_STATE;

    modport master (
        output FRAME_TICK, PADDLE_POSITION, SERVE,
        input  BALL_X, BALL_Y, BALL_VISIBLE, SCORE, MISSES, GAME_STATE
    );

    modport slave (
        input  FRAME_TICK, PADDLE_POSITION, SERVE,
        output BALL_X, BALL_Y, BALL_VISIBLE, SCORE, MISSES, GAME_STATE
    );
endinterface

// File: rtl/pong_ball_controller.sv
// rtl/pong_ball_controller.sv - per-frame ball motion, collisions, serve/miss timing and scoring for pong
module pong_ball_controller #(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int BORDER      = 5,
    parameter int BALL_SIZE   = 8,
    parameter int PADDLE_X    = 16,
    parameter int PADDLE_W    = 8,
    parameter int PADDLE_H    = 64,
    parameter int SPEED       = 2,
    parameter int SERVE_DELAY = 60,
    parameter int MISS_FRAMES = 30,
    parameter int MAX_MISSES  = 3
) (
    input  logic                    SYSTEM_CLOCK,
    input  logic                    RESET,
    pong_ball_controller_if.slave   bus
);
    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_SERVE_WAIT = 3'd1,
        S_PLAY       = 3'd2,
        S_MISS       = 3'd3,
        S_GAME_OVER  = 3'd4
    } state_t;

    localparam logic [10:0] CX        = 11'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [10:0] CY        = 11'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [10:0] BSZ       = 11'(BALL_SIZE);
    localparam logic [10:0] SPD       = 11'(SPEED);
    localparam logic [10:0] BRD       = 11'(BORDER);
    localparam logic [10:0] TOP_LIM   = 11'(BORDER + SPEED);
    localparam logic [10:0] BOT_LIM   = 11'(SCREEN_H - BORDER - SPEED);
    localparam logic [10:0] BOT_Y     = 11'(SCREEN_H - BORDER - BALL_SIZE);
    localparam logic [10:0] RIGHT_LIM = 11'(SCREEN_W - BORDER - SPEED);
    localparam logic [10:0] RIGHT_X   = 11'(SCREEN_W - BORDER - BALL_SIZE);
    localparam logic [10:0] FACE      = 11'(PADDLE_X + PADDLE_W);
    localparam logic [10:0] LEFT_LIM  = 11'(PADDLE_X + PADDLE_W + SPEED);
    localparam logic [10:0] PAD_H     = 11'(PADDLE_H);
    localparam logic [7:0]  SERVE_CNT = 8'(SERVE_DELAY);
    localparam logic [7:0]  MISS_CNT  = 8'(MISS_FRAMES);
    localparam logic [1:0]  MISS_MAX  = 2'(MAX_MISSES);

    state_t      state_q, state_d;
    logic [10:0] x_q, x_d, y_q, y_d;
    logic        dx_q, dx_d;      // 1 = moving right
    logic        dy_q, dy_d;      // 1 = moving down
    logic        tog_q, tog_d;    // vertical direction of the next serve, 1 = down
    logic [7:0]  score_q, score_d;
    logic [1:0]  misses_q, misses_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        serve_q;

    logic        serve_edge;
    logic        tick;
    logic [10:0] pad_top;
    logic        overlap;

    assign serve_edge = bus.SERVE & ~serve_q;
    assign tick       = bus.FRAME_TICK;
    assign pad_top    = BRD + {3'b000, bus.PADDLE_POSITION};
    assign overlap    = (y_q + BSZ > pad_top) && (y_q < pad_top + PAD_H);

    assign bus.BALL_X       = x_q;
    assign bus.BALL_Y       = y_q;
    assign bus.BALL_VISIBLE = (state_q == S_SERVE_WAIT) || (state_q == S_PLAY);
    assign bus.SCORE        = score_q;
    assign bus.MISSES       = misses_q;
    assign bus.GAME_STATE   = state_q;

    always_ff @(posedge SYSTEM_CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= S_IDLE;
            x_q      <= CX;
            y_q      <= CY;
            dx_q     <= 1'b1;
            dy_q     <= 1'b1;
            tog_q    <= 1'b1;
            score_q  <= 8'd0;
            misses_q <= 2'd0;
            cnt_q    <= 8'd0;
            serve_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            tog_q    <= tog_d;
            score_q  <= score_d;
            misses_q <= misses_d;
            cnt_q    <= cnt_d;
            serve_q  <= bus.SERVE;
        end
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        tog_d    = tog_q;
        score_d  = score_q;
        misses_d = misses_q;
        cnt_d    = cnt_q;
        case (state_q)
            // A serve edge is taken on any cycle, not only on a frame tick.
            S_IDLE, S_GAME_OVER: begin
                if (serve_edge) begin
                    if (state_q == S_GAME_OVER) begin
                        score_d  = 8'd0;
                        misses_d = 2'd0;
                    end
                    state_d = S_SERVE_WAIT;
                    x_d     = CX;
                    y_d     = CY;
                    dx_d    = 1'b1;
                    dy_d    = tog_q;
                    cnt_d   = SERVE_CNT;
                end
            end
            S_SERVE_WAIT: begin
                if (tick) begin
                    if (cnt_q == 8'd1) state_d = S_PLAY;
                    else               cnt_d   = cnt_q - 8'd1;
                end
            end
            S_PLAY: begin
                if (tick) begin
                    if (dy_q) begin
                        if (y_q + BSZ >= BOT_LIM) begin
                            y_d  = BOT_Y;
                            dy_d = 1'b0;
                        end else begin
                            y_d = y_q + SPD;
                        end
                    end else if (y_q <= TOP_LIM) begin
                        y_d  = BRD;
                        dy_d = 1'b1;
                    end else begin
                        y_d = y_q - SPD;
                    end

                    if (dx_q) begin
                        if (x_q + BSZ >= RIGHT_LIM) begin
                            x_d  = RIGHT_X;
                            dx_d = 1'b0;
                        end else begin
                            x_d = x_q + SPD;
                        end
                    end else if (x_q <= LEFT_LIM) begin
                        if (overlap) begin
                            x_d  = FACE;
                            dx_d = 1'b1;
                            if (score_q != 8'hFF) score_d = score_q + 8'd1;
                        end else begin
                            // The ball freezes where it slipped past the paddle.
                            state_d  = S_MISS;
                            misses_d = misses_q + 2'd1;
                            cnt_d    = MISS_CNT;
                            x_d      = x_q;
                            y_d      = y_q;
                            dy_d     = dy_q;
                        end
                    end else begin
                        x_d = x_q - SPD;
                    end
                end
            end
            S_MISS: begin
                if (tick) begin
                    if (cnt_q == 8'd1) begin
                        if (misses_q == MISS_MAX) begin
                            state_d = S_GAME_OVER;
                        end else begin
                            tog_d   = ~tog_q;
                            state_d = S_SERVE_WAIT;
                            x_d     = CX;
                            y_d     = CY;
                            dx_d    = 1'b1;
                            dy_d    = ~tog_q;
                            cnt_d   = SERVE_CNT;
                        end
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_pong_ball_controller.sv
// tb/tb_pong_ball_controller.sv - scoreboard bench for pong_ball_controller with hand-computed trajectories
module tb_pong_ball_controller;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pong_ball_controller_if bus ();
    pong_ball_controller_if sbus ();

    pong_ball_controller #(.SERVE_DELAY(4), .MISS_FRAMES(3)) dut (
        .SYSTEM_CLOCK (clk),
        .RESET        (rst_n),
        .bus          (bus.slave)
    );

    // Small court where the paddle spans the full height, so every return is a hit.
    pong_ball_controller #(.SCREEN_W(64), .SCREEN_H(80), .SERVE_DELAY(4), .MISS_FRAMES(3)) dut_sat (
        .SYSTEM_CLOCK (clk),
        .RESET        (rst_n),
        .bus          (sbus.slave)
    );

    localparam logic [2:0] IDLE = 3'd0, SW = 3'd1, PLAY = 3'd2, MISS = 3'd3, OVER = 3'd4;

    typedef struct {
        int          id;
        logic [2:0]  st;
        logic [10:0] x;
        logic [10:0] y;
        logic        vis;
        logic [7:0]  sc;
        logic [1:0]  mi;
        bit          cxy;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input int id, input string what, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL id=%0d %s actual=%0d expected=%0d", id, what, act, exp);
        end
    endtask

    task automatic expect_out(input int id, input logic [2:0] st, input logic [10:0] x, input logic [10:0] y,
                              input logic vis, input logic [7:0] sc, input logic [1:0] mi, input bit cxy);
        exp_t e;
        e.id = id; e.st = st; e.x = x; e.y = y; e.vis = vis; e.sc = sc; e.mi = mi; e.cxy = cxy;
        sb_q.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk(e.id, "state", int'(bus.GAME_STATE), int'(e.st));
                chk(e.id, "visible", int'(bus.BALL_VISIBLE), int'(e.vis));
                chk(e.id, "score", int'(bus.SCORE), int'(e.sc));
                chk(e.id, "misses", int'(bus.MISSES), int'(e.mi));
                if (e.cxy) begin
                    chk(e.id, "ball_x", int'(bus.BALL_X), int'(e.x));
                    chk(e.id, "ball_y", int'(bus.BALL_Y), int'(e.y));
                end
            end
        end
    end

    task automatic tick(input bit with_serve);
        @(posedge clk);
        #1;
        bus.FRAME_TICK = 1'b1;
        if (with_serve) bus.SERVE = 1'b1;
        @(posedge clk);
        #1;
        bus.FRAME_TICK = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick(1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.FRAME_TICK = 1'b0; bus.SERVE = 1'b0; bus.PADDLE_POSITION = 8'd200;
        sbus.FRAME_TICK = 1'b0; sbus.SERVE = 1'b0; sbus.PADDLE_POSITION = 8'd0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick(1'b0); expect_out(1, IDLE, 316, 236, 0, 0, 0, 1);

        @(posedge clk); #3 rst_n = 1'b0;
        expect_out(2, IDLE, 316, 236, 0, 0, 0, 1);
        @(posedge clk); #1 rst_n = 1'b1;
        tick(1'b0); expect_out(3, IDLE, 316, 236, 0, 0, 0, 1);
        tick(1'b0); expect_out(4, IDLE, 316, 236, 0, 0, 0, 1);

        @(posedge clk); #1 bus.SERVE = 1'b1;
        @(posedge clk); #1 expect_out(5, SW, 316, 236, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0); expect_out(6 + i, SW, 316, 236, 1, 0, 0, 1);
        end
        tick(1'b0); expect_out(9, PLAY, 316, 236, 1, 0, 0, 1);
        tick(1'b0); expect_out(10, PLAY, 318, 238, 1, 0, 0, 1);
        @(posedge clk); #1 bus.SERVE = 1'b0;
        @(posedge clk); #1 bus.SERVE = 1'b1;
        @(posedge clk); #1 expect_out(11, PLAY, 318, 238, 1, 0, 0, 1);

        ticks(113);
        tick(1'b0); expect_out(12, PLAY, 546, 466, 1, 0, 0, 1);
        tick(1'b0); expect_out(13, PLAY, 548, 467, 1, 0, 0, 1);
        tick(1'b0); expect_out(14, PLAY, 550, 465, 1, 0, 0, 1);
        ticks(37);
        tick(1'b0); expect_out(15, PLAY, 626, 389, 1, 0, 0, 1);
        tick(1'b0); expect_out(16, PLAY, 627, 387, 1, 0, 0, 1);
        tick(1'b0); expect_out(17, PLAY, 625, 385, 1, 0, 0, 1);
        ticks(188);
        tick(1'b0); expect_out(18, PLAY, 247, 7, 1, 0, 0, 1);
        tick(1'b0); expect_out(19, PLAY, 245, 5, 1, 0, 0, 1);
        tick(1'b0); expect_out(20, PLAY, 243, 7, 1, 0, 0, 1);
        ticks(108);
        tick(1'b0); expect_out(21, PLAY, 25, 225, 1, 0, 0, 1);
        tick(1'b0); expect_out(22, PLAY, 24, 227, 1, 1, 0, 1);
        bus.PADDLE_POSITION = 8'd100;
        tick(1'b0); expect_out(23, PLAY, 26, 229, 1, 1, 0, 1);
        ticks(300);
        tick(1'b0); expect_out(24, PLAY, 627, 103, 1, 1, 0, 1);
        ticks(300);
        tick(1'b0); expect_out(25, PLAY, 25, 425, 1, 1, 0, 1);
        tick(1'b0); expect_out(26, MISS, 25, 425, 0, 1, 1, 1);
        tick(1'b0); expect_out(27, MISS, 25, 425, 0, 1, 1, 1);
        tick(1'b0); expect_out(28, MISS, 25, 425, 0, 1, 1, 1);
        tick(1'b0); expect_out(29, SW, 316, 236, 1, 1, 1, 1);
        ticks(3);
        tick(1'b0); expect_out(30, PLAY, 316, 236, 1, 1, 1, 1);
        tick(1'b0); expect_out(31, PLAY, 318, 234, 1, 1, 1, 1);
        ticks(455);
        tick(1'b0); expect_out(32, PLAY, 25, 247, 1, 1, 1, 1);
        tick(1'b0); expect_out(33, MISS, 25, 247, 0, 1, 2, 1);
        ticks(3);   expect_out(34, SW, 316, 236, 1, 1, 2, 1);
        ticks(4);   expect_out(35, PLAY, 316, 236, 1, 1, 2, 1);
        tick(1'b0); expect_out(36, PLAY, 318, 238, 1, 1, 2, 1);
        ticks(455);
        tick(1'b0); expect_out(37, PLAY, 25, 225, 1, 1, 2, 1);
        tick(1'b0); expect_out(38, MISS, 25, 225, 0, 1, 3, 1);
        ticks(2);   expect_out(39, MISS, 0, 0, 0, 1, 3, 0);
        tick(1'b0); expect_out(40, OVER, 0, 0, 0, 1, 3, 0);
        tick(1'b0); expect_out(41, OVER, 0, 0, 0, 1, 3, 0);
        @(posedge clk); #1 bus.SERVE = 1'b0;
        tick(1'b0); expect_out(42, OVER, 0, 0, 0, 1, 3, 0);
        tick(1'b1); expect_out(43, SW, 316, 236, 1, 0, 0, 1);
        ticks(3);   expect_out(44, SW, 316, 236, 1, 0, 0, 1);
        tick(1'b0); expect_out(45, PLAY, 316, 236, 1, 0, 0, 1);
        tick(1'b0); expect_out(46, PLAY, 318, 238, 1, 0, 0, 1);
        @(posedge clk); #3 rst_n = 1'b0;
        expect_out(47, IDLE, 316, 236, 0, 0, 0, 1);
        @(posedge clk); #1 rst_n = 1'b1;

        @(posedge clk); #1 sbus.SERVE = 1'b1; sbus.FRAME_TICK = 1'b1;
        repeat (9000) @(posedge clk);
        #1 sbus.FRAME_TICK = 1'b0;
        @(negedge clk);
        chk(48, "sat_state", int'(sbus.GAME_STATE), int'(PLAY));
        chk(48, "sat_score", int'(sbus.SCORE), 255);
        chk(48, "sat_misses", int'(sbus.MISSES), 0);
        chk(49, "scoreboard_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
